// File: rtl/gate_pkg.sv
// Shared definitions for the gate sweep checker: op encodings, FSM states,
// op legality check and the N-input expected-output routine.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  localparam int MAX_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    op_legal = (op <= OP_XNOR);
  endfunction

  function automatic logic parity8(input logic [MAX_N-1:0] v);
    parity8 = ^v;
  endfunction

  // Unused lanes are masked so they read as 1 for AND and 0 for OR/XOR.
  function automatic logic gate_expected(input logic [2:0] op,
                                         input logic [MAX_N-1:0] v,
                                         input logic [MAX_N-1:0] mask);
    logic all_s;
    logic any_s;
    logic odd_s;
    all_s = &(v | ~mask);
    any_s = |(v & mask);
    odd_s = parity8(v & mask);
    case (op)
      OP_AND:  gate_expected = all_s;
      OP_OR:   gate_expected = any_s;
      OP_XOR:  gate_expected = odd_s;
      OP_NAND: gate_expected = ~all_s;
      OP_NOR:  gate_expected = ~any_s;
      OP_XNOR: gate_expected = ~odd_s;
      default: gate_expected = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gate_ref.sv
// Combinational reference model: expected gate output for the current
// stimulus vector under the latched op.
module gate_ref
  import gate_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] vec,
  input  logic [2:0]   op,
  output logic         expected
);

  logic [MAX_N-1:0] vec_ext_s;
  logic [MAX_N-1:0] mask_s;

  // Widen the vector to the package width and evaluate the reference gate.
  always_comb begin
    vec_ext_s = {MAX_N{1'b0}};
    mask_s    = {MAX_N{1'b0}};
    for (int i = 0; i < N; i++) begin
      vec_ext_s[i] = vec[i];
      mask_s[i]    = 1'b1;
    end
    expected = gate_expected(op, vec_ext_s, mask_s);
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweep of an N-input gate: drives every vector for
// DWELL cycles, compares the gate output at the end of each window.
module gate_sweep_checker
  import gate_pkg::*;
#(
  parameter int N     = 2,
  parameter int DWELL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic         dut_o,
  output logic [N-1:0] vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         op_err,
  output logic [N:0]   err_cnt,
  output logic [N-1:0] first_fail,
  output logic         first_fail_vld
);

  localparam logic [7:0]   DWELL_LAST = 8'(DWELL - 1);
  localparam logic [N-1:0] VEC_ONE    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N:0]   ERR_ONE    = {{N{1'b0}}, 1'b1};

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] dwell_r;
  logic [2:0] op_r;
  logic       expected_s;
  logic       start_ok_s;
  logic       last_win_s;
  logic       mismatch_s;

  gate_ref #(.N(N)) u_gate_ref (
    .vec      (vec),
    .op       (op_r),
    .expected (expected_s)
  );

  assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign last_win_s = (dwell_r == DWELL_LAST);
  assign mismatch_s = (dut_o != expected_s);
  assign pass       = done && (err_cnt == {(N+1){1'b0}}) && !op_err;

  // Next-state decode: start launches a sweep (or flags a bad op), the last
  // window of the all-ones vector finishes it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s = op_legal(op) ? ST_RUN : ST_DONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (last_win_s && (&vec)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s == ST_RUN);
      done    <= (state_nxt_s == ST_DONE);
    end
  end

  // Sweep datapath: vector/dwell stepping and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec            <= {N{1'b0}};
      dwell_r        <= 8'd0;
      op_r           <= 3'd0;
      op_err         <= 1'b0;
      err_cnt        <= {(N+1){1'b0}};
      first_fail     <= {N{1'b0}};
      first_fail_vld <= 1'b0;
    end else if (start_ok_s) begin
      vec            <= {N{1'b0}};
      dwell_r        <= 8'd0;
      op_r           <= op;
      op_err         <= !op_legal(op);
      err_cnt        <= {(N+1){1'b0}};
      first_fail     <= {N{1'b0}};
      first_fail_vld <= 1'b0;
    end else if (state_r == ST_RUN) begin
      if (last_win_s) begin
        dwell_r <= 8'd0;
        // Wraps to zero after the all-ones vector, which is the idle value.
        vec     <= vec + VEC_ONE;
        if (mismatch_s) begin
          err_cnt <= err_cnt + ERR_ONE;
          if (!first_fail_vld) begin
            first_fail     <= vec;
            first_fail_vld <= 1'b1;
          end
        end
      end else begin
        dwell_r <= dwell_r + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: two instances (N=2/DWELL=1 and
// N=3/DWELL=3), sweep results predicted into a scoreboard and popped at DONE.
module tb_gate_sweep_checker;

  typedef struct {
    int cycles;
    int err;
    int ff;
    bit ffv;
    bit op_err;
    bit pass;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start_a, start_b;
  logic [2:0] op_a, op_b;
  logic       dut_o_a, dut_o_b;
  logic [1:0] vec_a;
  logic [2:0] vec_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic       op_err_a, op_err_b, ffv_a, ffv_b;
  logic [2:0] err_cnt_a;
  logic [3:0] err_cnt_b;
  logic [1:0] ff_a;
  logic [2:0] ff_b;
  int         mode_a;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  gate_sweep_checker #(.N(2), .DWELL(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .op(op_a), .dut_o(dut_o_a),
    .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a), .op_err(op_err_a),
    .err_cnt(err_cnt_a), .first_fail(ff_a), .first_fail_vld(ffv_a)
  );

  gate_sweep_checker #(.N(3), .DWELL(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .op(op_b), .dut_o(dut_o_b),
    .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b), .op_err(op_err_b),
    .err_cnt(err_cnt_b), .first_fail(ff_b), .first_fail_vld(ffv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate under test for instance A: 0 AND, 1 XOR; instance B is stuck at 0.
  always_comb begin
    case (mode_a)
      0:       dut_o_a = &vec_a;
      1:       dut_o_a = ^vec_a;
      default: dut_o_a = 1'b0;
    endcase
  end
  assign dut_o_b = 1'b0;

  function automatic int popcnt(input int v, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += (v >> i) & 1;
    return c;
  endfunction

  function automatic bit ref_gate(input int o, input int v, input int n);
    int c = popcnt(v, n);
    case (o)
      0: return c == n;
      1: return c > 0;
      2: return c % 2 == 1;
      3: return c != n;
      4: return c == 0;
      5: return c % 2 == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit gut(input int m, input int v, input int n);
    case (m)
      0: return popcnt(v, n) == n;
      1: return popcnt(v, n) % 2 == 1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t predict(input int o, input int m, input int n, input int dwell);
    exp_t e;
    e.err = 0; e.ff = 0; e.ffv = 0;
    if (o > 5) begin
      e.cycles = 0;
      e.op_err = 1;
    end else begin
      e.cycles = (1 << n) * dwell;
      e.op_err = 0;
      for (int v = 0; v < (1 << n); v++) begin
        if (ref_gate(o, v, n) != gut(m, v, n)) begin
          e.err++;
          if (!e.ffv) begin
            e.ff  = v;
            e.ffv = 1;
          end
        end
      end
    end
    e.pass = (e.err == 0) && !e.op_err;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_a();
    check("rst_vec", 32'(vec_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_op_err", 32'(op_err_a), 32'd0);
    check("rst_err_cnt", 32'(err_cnt_a), 32'd0);
    check("rst_first_fail", 32'(ff_a), 32'd0);
    check("rst_ffv", 32'(ffv_a), 32'd0);
  endtask

  // One sweep on instance A (use_b=0) or B (use_b=1); mid pulses start in RUN.
  task automatic sweep(input bit use_b, input logic [2:0] o, input int m, input bit mid);
    exp_t e;
    int   cyc;
    int   dwell;
    dwell = use_b ? 3 : 1;
    sb.push_back(predict(o, m, use_b ? 3 : 2, dwell));
    @(negedge clk);
    if (use_b) begin op_b = o; start_b = 1'b1; end
    else begin op_a = o; start_a = 1'b1; end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    op_a = 3'd6; op_b = 3'd6;
    cyc = 0;
    while ((use_b ? busy_b : busy_a) === 1'b1 && cyc < 200) begin
      check("run_vec", use_b ? 32'(vec_b) : 32'(vec_a), 32'(cyc / dwell));
      check("run_done_low", use_b ? 32'(done_b) : 32'(done_a), 32'd0);
      if (use_b) start_b = mid && (cyc == 1);
      else start_a = mid && (cyc == 1);
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0; start_b = 1'b0;
    e = sb.pop_front();
    check("run_cycles", 32'(cyc), 32'(e.cycles));
    if (use_b) begin
      check("done", 32'(done_b), 32'd1);
      check("busy_low", 32'(busy_b), 32'd0);
      check("vec_idle", 32'(vec_b), 32'd0);
      check("err_cnt", 32'(err_cnt_b), 32'(e.err));
      check("first_fail", 32'(ff_b), 32'(e.ff));
      check("first_fail_vld", 32'(ffv_b), 32'(e.ffv));
      check("op_err", 32'(op_err_b), 32'(e.op_err));
      check("pass", 32'(pass_b), 32'(e.pass));
    end else begin
      check("done", 32'(done_a), 32'd1);
      check("busy_low", 32'(busy_a), 32'd0);
      check("vec_idle", 32'(vec_a), 32'd0);
      check("err_cnt", 32'(err_cnt_a), 32'(e.err));
      check("first_fail", 32'(ff_a), 32'(e.ff));
      check("first_fail_vld", 32'(ffv_a), 32'(e.ffv));
      check("op_err", 32'(op_err_a), 32'(e.op_err));
      check("pass", 32'(pass_a), 32'(e.pass));
    end
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1;
    op_a = 3'd0; op_b = 3'd0; mode_a = 0;
    repeat (3) @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check_reset_a();
    check("rst_b_busy", 32'(busy_b), 32'd0);

    // AND against AND: clean sweep.
    mode_a = 0;
    sweep(1'b0, 3'd0, 0, 1'b0);
    // OR against AND: mismatches on 01 and 10.
    sweep(1'b0, 3'd1, 0, 1'b0);
    check("or_err_const", 32'(err_cnt_a), 32'd2);
    check("or_ff_const", 32'(ff_a), 32'd1);
    // NAND against stuck-at-0, 3 inputs, 3-cycle dwell.
    sweep(1'b1, 3'd3, 2, 1'b0);
    check("nand_err_const", 32'(err_cnt_b), 32'd7);
    // Invalid op from DONE.
    sweep(1'b0, 3'd7, 0, 1'b0);
    check("inv_pass_const", 32'(pass_a), 32'd0);
    // Invalid op 6 as well.
    sweep(1'b0, 3'd6, 0, 1'b0);

    // Reset during the second vector.
    @(negedge clk); op_a = 3'd0; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("mid_vec0", 32'(vec_a), 32'd0);
    @(negedge clk);
    check("mid_vec1", 32'(vec_a), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_a();
    sweep(1'b0, 3'd0, 0, 1'b0);

    // XOR DUT: start ignored mid-RUN, then restart from DONE.
    mode_a = 1;
    sweep(1'b0, 3'd2, 1, 1'b1);
    sweep(1'b0, 3'd2, 1, 1'b0);
    check("xor_pass_const", 32'(pass_a), 32'd1);
    // XNOR against XOR: every vector mismatches.
    sweep(1'b0, 3'd5, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 Parameter N, default 2, number of gate inputs swept (legal 2..8).
REQ-002 Parameter DWELL, default 1, cycles each input vector is held before sampling (legal 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  begin a sweep; sampled only in IDLE or DONE.
REQ-006 op  input  3  expected gate function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6, 7 invalid.
REQ-007 dut_o  input  1  output of the gate under test.
REQ-008 vec  output  N  stimulus driven to gate-under-test inputs, bit 0 = input 1.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  high while in DONE.
REQ-011 pass  output  1  valid when done; 1 iff err_cnt = 0 and op_err = 0.
REQ-012 op_err  output  1  latched op was invalid.
REQ-013 err_cnt  output  N+1  number of mismatching vectors in the last sweep.
REQ-014 first_fail  output  N  vec value of the first mismatch.
REQ-015 first_fail_vld  output  1  first_fail holds a captured value.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE -> RUN on start with valid op; IDLE -> DONE on start with invalid op.
REQ-017 On the start cycle: op latched, err_cnt, first_fail, first_fail_vld, op_err cleared (op_err set if op invalid), vec = 0, dwell counter = 0.
REQ-018 In RUN each vec value held exactly DWELL cycles; dut_o compared with expected on the last cycle of the window.
REQ-019 Expected = reduction of latched op over vec (AND: all ones; OR: any one; XOR: odd parity; NAND, NOR, XNOR: inverses).
REQ-020 On mismatch err_cnt increments by 1; if first_fail_vld = 0, first_fail <= vec and first_fail_vld <= 1 in the same edge.
REQ-021 vec increments by 1 after each window; after window for vec = 2^N-1, RUN -> DONE and vec returns to 0.
REQ-022 Sweep length exactly 2^N * DWELL RUN cycles; err_cnt max 2^N, no overflow by width.
REQ-023 DONE holds all results and done = 1 until start (restarts per REQ-016/017, going through RUN or back to DONE) or reset.
REQ-024 start while in RUN ignored; op changes outside the start cycle ignored.
REQ-025 Invalid op: DONE entered one cycle after start, op_err = 1, pass = 0, err_cnt = 0, vec stays 0.
REQ-026 busy, done mutually exclusive; both low in IDLE.

Reset
REQ-027 rst_n = 0 at a clock edge forces IDLE from any state, including mid-RUN, discarding partial results.
REQ-028 Reset values: vec 0, busy 0, done 0, pass 0, op_err 0, err_cnt 0, first_fail 0, first_fail_vld 0, dwell counter 0, latched op 0.
REQ-029 start asserted during reset has no effect; first start after reset release honoured.

Structure
REQ-030 Shared package gate_pkg holds op encoding constants, legal-op check and the N-input expected-function routine.
REQ-031 One combinational sub-module gate_ref (parameter N; inputs vec, op; output expected) instantiated once.
REQ-032 No latches; single clock domain; all outputs registered except pass, which may be decoded from registered state.

Verification
REQ-033 N=2, DWELL=1, op=0, dut_o = AND of vec -> vec 00,01,10,11 one cycle each, done after 4 RUN cycles, pass=1, err_cnt=0.
REQ-034 N=2, op=1 (OR), DUT is AND -> mismatches at 01, 10; err_cnt=2, first_fail=01, first_fail_vld=1, pass=0.
REQ-035 N=3, DWELL=3, op=3 (NAND), dut_o stuck at 0 -> 24 RUN cycles, err_cnt=7, first_fail=000; each vec held 3 cycles.
REQ-036 op=7 with start -> DONE next cycle, op_err=1, pass=0, err_cnt=0, busy never asserted.
REQ-037 N=2, rst_n=0 during second vector -> IDLE next edge, all outputs at reset values; a new start then gives a full clean sweep.
REQ-038 start pulsed mid-RUN, then start in DONE with op=2 against XOR DUT -> first sweep unaffected; second sweep pass=1.
